imem_loader: RTL

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 27 ++
 rtl/imem_loader_word_packer.sv | 56 +++++
 rtl/imem_loader.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader_pkg
// Description : Shared types and constants for the instruction-memory boot
//               loader: FSM state encoding, sync byte and length width.
//               Optional feature macro: LOADER_CHECKSUM_EN (adds CSUM state).
// Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int         LEN_WIDTH = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LEN_LO = 3'd1,
    LEN_HI = 3'd2,
    DATA   = 3'd3,
`ifdef LOADER_CHECKSUM_EN
    CSUM   = 3'd4,
`endif
    DONE   = 3'd5,
    ERROR  = 3'd6
  } state_t;

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_word_packer.sv
`default_nettype none
// ============================================================================
// Module      : word_packer
// Description : Assembles four accepted bytes into one 32-bit word,
//               little-endian (first byte lands in word[7:0]), and pulses
//               word_valid for one cycle after the 4th byte.
// Ports       : clk, rst        - clock, synchronous active-high reset
//               clr             - return the byte index to 0
//               byte_valid      - byte_data is accepted this cycle
//               byte_data[7:0]  - incoming byte
//               word_valid      - one-cycle pulse, word holds a fresh word
//               word[31:0]      - assembled word (held until next word)
// Revision    : 1.0 - initial release
// ============================================================================
module word_packer (
  input  logic        clk,
  input  logic        rst,
  input  logic        clr,
  input  logic        byte_valid,
  input  logic [7:0]  byte_data,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0]  r_idx;
  logic [23:0] r_shift;     // the three bytes preceding the current one
  logic        r_word_valid;
  logic [31:0] r_word;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx        <= 2'd0;
      r_shift      <= 24'd0;
      r_word_valid <= 1'b0;
      r_word       <= 32'd0;
    end else begin
      r_word_valid <= 1'b0;
      if (clr) begin
        r_idx <= 2'd0;
      end else if (byte_valid) begin
        r_idx   <= r_idx + 2'd1;
        // Shift in from the top so the oldest byte ends up lowest.
        r_shift <= {byte_data, r_shift[23:8]};
        if (r_idx == 2'd3) begin
          r_word_valid <= 1'b1;
          r_word       <= {byte_data, r_shift};
        end
      end
    end
  end

  assign word_valid = r_word_valid;
  assign word       = r_word;

endmodule : word_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Byte-stream boot loader. Waits for sync byte 0xA5, reads a
//               16-bit little-endian word count N, then writes N 32-bit
//               little-endian words to instruction memory at 0,4,8,...
//               The core is held in reset until the image is loaded.
//               Macro LOADER_CHECKSUM_EN adds a trailing XOR checksum byte.
// Ports       : clk, rst             - clock, synchronous active-high reset
//               in_data/valid/ready  - byte stream handshake
//               we, waddr, wdata     - instruction memory write port
//               cpu_hold             - high except after a successful load
//               done / err           - load complete / load aborted
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 32,
  parameter int INSTR_WIDTH   = 32,
  parameter int DEPTH         = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [7:0]               in_data,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     we,
  output logic [ADDRESS_WIDTH-1:0] waddr,
  output logic [INSTR_WIDTH-1:0]   wdata,
  output logic                     cpu_hold,
  output logic                     done,
  output logic                     err
);

  localparam logic [31:0] c_depth = 32'(DEPTH);
`ifdef LOADER_CHECKSUM_EN
  localparam state_t c_after_data = CSUM;
`else
  localparam state_t c_after_data = DONE;
`endif

  state_t                 r_state;
  state_t                 w_state_nxt;
  logic [LEN_WIDTH-1:0]   r_len;
  logic [LEN_WIDTH-1:0]   r_wcnt;
  logic [LEN_WIDTH-1:0]   w_len_full;
  logic                   w_acc;
  logic                   w_sync;
  logic                   w_we;
  logic                   w_last;
  logic [31:0]            w_word;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]             r_csum;
`endif

  // Full count as it will stand once the high byte is taken in LEN_HI.
  assign w_len_full = {in_data, r_len[7:0]};
  assign w_last     = (r_wcnt == r_len - 16'd1);
  // The only stall: the write cycle of the final word, so no byte can slip
  // into the packer (or be taken as checksum) before the FSM moves on.
  assign in_ready   = !((r_state == DATA) && w_we && w_last);
  assign w_acc      = in_valid && in_ready;
  assign w_sync     = w_acc && (in_data == SYNC_BYTE);

  word_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (r_state != DATA),
    .byte_valid (w_acc && (r_state == DATA)),
    .byte_data  (in_data),
    .word_valid (w_we),
    .word       (w_word)
  );

  assign we    = w_we;
  assign wdata = w_word;
  assign waddr = ADDRESS_WIDTH'({r_wcnt, 2'b00});

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_len   <= '0;
      r_wcnt  <= '0;
`ifdef LOADER_CHECKSUM_EN
      r_csum  <= 8'd0;
`endif
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        IDLE, DONE, ERROR: begin
          // A new sync starts a fresh image; clear per-image state.
          if (w_sync) begin
            r_len  <= '0;
            r_wcnt <= '0;
`ifdef LOADER_CHECKSUM_EN
            r_csum <= 8'd0;
`endif
          end
        end
        LEN_LO: if (w_acc) r_len[7:0]  <= in_data;
        LEN_HI: if (w_acc) r_len[15:8] <= in_data;
        DATA: begin
          if (w_we) r_wcnt <= r_wcnt + 16'd1;
`ifdef LOADER_CHECKSUM_EN
          if (w_acc) r_csum <= r_csum ^ in_data;
`endif
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    done        = 1'b0;
    err         = 1'b0;
    cpu_hold    = 1'b1;
    case (r_state)
      IDLE:   if (w_sync) w_state_nxt = LEN_LO;
      LEN_LO: if (w_acc)  w_state_nxt = LEN_HI;
      LEN_HI: begin
        if (w_acc) begin
          if (32'(w_len_full) > c_depth) w_state_nxt = ERROR;
          else if (w_len_full == '0)     w_state_nxt = c_after_data;
          else                           w_state_nxt = DATA;
        end
      end
      DATA:   if (w_we && w_last) w_state_nxt = c_after_data;
`ifdef LOADER_CHECKSUM_EN
      CSUM:   if (w_acc) w_state_nxt = (in_data == r_csum) ? DONE : ERROR;
`endif
      DONE: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
        if (w_sync) w_state_nxt = LEN_LO;
      end
      ERROR: begin
        err = 1'b1;
        if (w_sync) w_state_nxt = LEN_LO;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

endmodule : imem_loader
`default_nettype wire
